// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC generator, in-order imem requester and fetch FIFO with redirect flush.
// Optional IFU_MISALIGN_CHK_EN adds a sticky misaligned-redirect error that parks fetch.
module instr_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  ImemReq_o,
    output logic [ADDR_WIDTH-1:0] ImemAddr_o,
    input  logic                  ImemRdy_i,
    input  logic                  ImemRValid_i,
    input  logic [DATA_WIDTH-1:0] ImemRData_i,
    output logic [DATA_WIDTH-1:0] Instr_o,
    output logic [ADDR_WIDTH-1:0] InstrPC_o,
    output logic                  InstrValid_o,
    input  logic                  InstrReady_i,
    input  logic                  Redirect_i,
    input  logic [ADDR_WIDTH-1:0] RedirectPC_i
`ifdef IFU_MISALIGN_CHK_EN
    ,
    output logic                  MisalignErr_o
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH);
    logic [ADDR_WIDTH-1:0] fetch_pc, resp_pc, target;
    logic [CW:0]           outstanding, drop, count, live;
    logic [CW+1:0]         credit;
    logic [CW-1:0]         rd_ptr, wr_ptr;
    logic [DATA_WIDTH-1:0] instr_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem [FIFO_DEPTH];
    logic                  parked, accept, push, pop, dropping;
`ifdef IFU_MISALIGN_CHK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) MisalignErr_o <= 1'b0;
        else if (Redirect_i && |RedirectPC_i[1:0]) MisalignErr_o <= 1'b1;
    end
    assign parked = MisalignErr_o;
`else
    assign parked = 1'b0;
`endif
    assign target       = RedirectPC_i & ~ADDR_WIDTH'(3);
    assign live         = outstanding - drop;
    // Credit counts buffered plus live in-flight words so a response always has a free slot.
    assign credit       = {1'b0, count} + {1'b0, live};
    assign ImemReq_o    = rst_ni && !Redirect_i && !parked && credit < (CW+2)'(FIFO_DEPTH)
                          && outstanding < (CW+1)'(FIFO_DEPTH);
    assign ImemAddr_o   = fetch_pc;
    assign accept       = ImemReq_o && ImemRdy_i;
    assign dropping     = drop != '0;
    assign push         = ImemRValid_i && !dropping && !Redirect_i;
    assign InstrValid_o = count != '0;
    assign pop          = InstrValid_o && InstrReady_i && !Redirect_i;
    assign Instr_o      = instr_mem[rd_ptr];
    assign InstrPC_o    = pc_mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding + (CW+1)'(accept) - (CW+1)'(ImemRValid_i);
            if (Redirect_i) begin
                fetch_pc <= target;
                resp_pc  <= target;
                drop     <= outstanding - (CW+1)'(ImemRValid_i);
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (accept) fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
                if (push) begin
                    resp_pc <= resp_pc + ADDR_WIDTH'(4);
                    wr_ptr  <= wr_ptr + CW'(1);
                end
                if (ImemRValid_i && dropping) drop <= drop - (CW+1)'(1);
                if (pop) rd_ptr <= rd_ptr + CW'(1);
                count <= count + (CW+1)'(push) - (CW+1)'(pop);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem[wr_ptr] <= ImemRData_i;
            pc_mem[wr_ptr]    <= resp_pc;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios against a 1-cycle in-order memory model.
module tb_instr_fetch_unit;
    logic        clk_i = 0, rst_ni = 1, ImemRdy_i = 1, ImemRValid_i = 0;
    logic        InstrReady_i = 1, Redirect_i = 0;
    logic [31:0] ImemRData_i = 0, RedirectPC_i = 0;
    logic        ImemReq_o, InstrValid_o;
    logic [31:0] ImemAddr_o, Instr_o, InstrPC_o;
`ifdef IFU_MISALIGN_CHK_EN
    logic        MisalignErr_o;
`endif
    int          checks = 0, errors = 0;
    bit          hold = 0;
    logic [31:0] q_addr[$];

    instr_fetch_unit dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ImemReq_o(ImemReq_o), .ImemAddr_o(ImemAddr_o), .ImemRdy_i(ImemRdy_i),
        .ImemRValid_i(ImemRValid_i), .ImemRData_i(ImemRData_i),
        .Instr_o(Instr_o), .InstrPC_o(InstrPC_o), .InstrValid_o(InstrValid_o),
        .InstrReady_i(InstrReady_i), .Redirect_i(Redirect_i), .RedirectPC_i(RedirectPC_i)
`ifdef IFU_MISALIGN_CHK_EN
        , .MisalignErr_o(MisalignErr_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory: records accepts on the edge, answers the oldest one in the following cycle.
    always @(posedge clk_i) begin
        if (!rst_ni) q_addr.delete();
        else begin
            if (ImemRValid_i) void'(q_addr.pop_front());
            if (ImemReq_o && ImemRdy_i) q_addr.push_back(ImemAddr_o);
        end
    end
    always @(negedge clk_i) begin
        ImemRValid_i = rst_ni && !hold && q_addr.size() != 0;
        ImemRData_i  = ImemRValid_i ? word(q_addr[0]) : 32'h0;
    end

    task automatic tick;
        @(negedge clk_i);
        #1;
    endtask

    task automatic do_reset;
        rst_ni = 0; hold = 0; Redirect_i = 0; InstrReady_i = 1;
        repeat (2) tick;
        rst_ni = 1;
        #1;
    endtask

    task automatic test_reset;
        #1 rst_ni = 0;
        repeat (2) tick;
        checks++;
        if (ImemReq_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", ImemReq_o); end
        checks++;
        if (InstrValid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", InstrValid_o); end
        rst_ni = 1;
        #1;
    endtask

    task automatic test_stream;
        bit          er [7] = '{1, 1, 0, 1, 1, 0, 1};
        logic [31:0] ea [7] = '{32'h0, 32'h4, 32'h0, 32'h8, 32'hC, 32'h0, 32'h10};
        bit          ev [7] = '{0, 0, 1, 1, 0, 1, 1};
        logic [31:0] ep [7] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h8, 32'hC};
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (ImemReq_o !== er[i] || (er[i] && ImemAddr_o !== ea[i])) begin
                errors++;
                $display("FAIL stream_req[%0d]: got req=%b addr=%h expected req=%b addr=%h", i, ImemReq_o, ImemAddr_o, er[i], ea[i]);
            end
            checks++;
            if (InstrValid_o !== ev[i] || (ev[i] && (InstrPC_o !== ep[i] || Instr_o !== word(ep[i])))) begin
                errors++;
                $display("FAIL stream_out[%0d]: got v=%b pc=%h ins=%h expected v=%b pc=%h", i, InstrValid_o, InstrPC_o, Instr_o, ev[i], ep[i]);
            end
            tick;
        end
    endtask

    task automatic test_backpressure;
        do_reset;
        InstrReady_i = 0;
        for (int i = 1; i <= 10; i++) begin
            tick;
            if (i >= 2) begin
                checks++;
                if (ImemReq_o !== 1'b0 || InstrValid_o !== 1'b1 || InstrPC_o !== 32'h0 || Instr_o !== word(32'h0)) begin
                    errors++;
                    $display("FAIL bp_hold[%0d]: got req=%b v=%b pc=%h ins=%h expected req=0 v=1 pc=0", i, ImemReq_o, InstrValid_o, InstrPC_o, Instr_o);
                end
            end
        end
        InstrReady_i = 1;
        tick;
        checks++;
        if (InstrValid_o !== 1'b1 || InstrPC_o !== 32'h4 || Instr_o !== word(32'h4) || ImemReq_o !== 1'b1 || ImemAddr_o !== 32'h8) begin
            errors++;
            $display("FAIL bp_second: got v=%b pc=%h req=%b addr=%h expected v=1 pc=4 req=1 addr=8", InstrValid_o, InstrPC_o, ImemReq_o, ImemAddr_o);
        end
        tick;
        checks++;
        if (InstrValid_o !== 1'b0 || ImemAddr_o !== 32'hC) begin
            errors++;
            $display("FAIL bp_gap: got v=%b addr=%h expected v=0 addr=c", InstrValid_o, ImemAddr_o);
        end
        tick;
        checks++;
        if (InstrValid_o !== 1'b1 || InstrPC_o !== 32'h8 || Instr_o !== word(32'h8)) begin
            errors++;
            $display("FAIL bp_third: got v=%b pc=%h expected v=1 pc=8", InstrValid_o, InstrPC_o);
        end
    endtask

    task automatic test_flush;
        do_reset;
        InstrReady_i = 0;
        repeat (3) tick;
        Redirect_i = 1; RedirectPC_i = 32'h40; InstrReady_i = 1;
        #1;
        checks++;
        if (ImemReq_o !== 1'b0 || InstrValid_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_cycle: got req=%b v=%b expected req=0 v=1", ImemReq_o, InstrValid_o);
        end
        tick;
        Redirect_i = 0;
        #1;
        checks++;
        if (InstrValid_o !== 1'b0 || ImemReq_o !== 1'b1 || ImemAddr_o !== 32'h40) begin
            errors++;
            $display("FAIL flush_after: got v=%b req=%b addr=%h expected v=0 req=1 addr=40", InstrValid_o, ImemReq_o, ImemAddr_o);
        end
        repeat (2) tick;
        checks++;
        if (InstrValid_o !== 1'b1 || InstrPC_o !== 32'h40 || Instr_o !== word(32'h40)) begin
            errors++;
            $display("FAIL flush_first: got v=%b pc=%h expected v=1 pc=40", InstrValid_o, InstrPC_o);
        end
    endtask

    task automatic test_redirect;
        do_reset;
        repeat (3) tick;
        hold = 1;
        repeat (2) tick;
        Redirect_i = 1; RedirectPC_i = 32'h100; hold = 0;
        #1;
        checks++;
        if (ImemReq_o !== 1'b0) begin errors++; $display("FAIL redir_req: got %b expected 0", ImemReq_o); end
        tick;
        Redirect_i = 0;
        #1;
        checks++;
        if (ImemReq_o !== 1'b0 || InstrValid_o !== 1'b0) begin
            errors++;
            $display("FAIL redir_drain: got req=%b v=%b expected req=0 v=0", ImemReq_o, InstrValid_o);
        end
        tick;
        checks++;
        if (ImemReq_o !== 1'b1 || ImemAddr_o !== 32'h100 || InstrValid_o !== 1'b0) begin
            errors++;
            $display("FAIL redir_newreq: got req=%b addr=%h v=%b expected req=1 addr=100 v=0", ImemReq_o, ImemAddr_o, InstrValid_o);
        end
        tick;
        checks++;
        if (InstrValid_o !== 1'b0) begin errors++; $display("FAIL redir_nowrong: got v=%b pc=%h expected v=0", InstrValid_o, InstrPC_o); end
        tick;
        checks++;
        if (InstrValid_o !== 1'b1 || InstrPC_o !== 32'h100 || Instr_o !== word(32'h100)) begin
            errors++;
            $display("FAIL redir_first: got v=%b pc=%h ins=%h expected v=1 pc=100", InstrValid_o, InstrPC_o, Instr_o);
        end
    endtask

    task automatic test_redirect_concurrent;
        do_reset;
        repeat (3) tick;
        hold = 1;
        tick;
        hold = 0;
        tick;
        Redirect_i = 1; RedirectPC_i = 32'h200;
        #1;
        checks++;
        if (ImemReq_o !== 1'b0) begin errors++; $display("FAIL conc_req: got %b expected 0", ImemReq_o); end
        tick;
        Redirect_i = 0;
        #1;
        checks++;
        if (ImemReq_o !== 1'b1 || ImemAddr_o !== 32'h200 || InstrValid_o !== 1'b0) begin
            errors++;
            $display("FAIL conc_newreq: got req=%b addr=%h v=%b expected req=1 addr=200 v=0", ImemReq_o, ImemAddr_o, InstrValid_o);
        end
        tick;
        checks++;
        if (InstrValid_o !== 1'b0) begin errors++; $display("FAIL conc_nowrong: got v=%b pc=%h expected v=0", InstrValid_o, InstrPC_o); end
        tick;
        checks++;
        if (InstrValid_o !== 1'b1 || InstrPC_o !== 32'h200 || Instr_o !== word(32'h200)) begin
            errors++;
            $display("FAIL conc_first: got v=%b pc=%h ins=%h expected v=1 pc=200", InstrValid_o, InstrPC_o, Instr_o);
        end
    endtask

    task automatic test_back_to_back;
        do_reset;
        hold = 1;
        repeat (2) tick;
        Redirect_i = 1; RedirectPC_i = 32'h300;
        tick;
        RedirectPC_i = 32'h380; hold = 0;
        #1;
        checks++;
        if (ImemReq_o !== 1'b0) begin errors++; $display("FAIL b2b_req: got %b expected 0", ImemReq_o); end
        tick;
        Redirect_i = 0;
        #1;
        checks++;
        if (ImemReq_o !== 1'b0) begin errors++; $display("FAIL b2b_drain: got req=%b expected 0", ImemReq_o); end
        tick;
        checks++;
        if (ImemReq_o !== 1'b1 || ImemAddr_o !== 32'h380) begin
            errors++;
            $display("FAIL b2b_newreq: got req=%b addr=%h expected req=1 addr=380", ImemReq_o, ImemAddr_o);
        end
        tick;
        checks++;
        if (InstrValid_o !== 1'b0) begin errors++; $display("FAIL b2b_nowrong: got v=%b pc=%h expected v=0", InstrValid_o, InstrPC_o); end
        tick;
        checks++;
        if (InstrValid_o !== 1'b1 || InstrPC_o !== 32'h380 || Instr_o !== word(32'h380)) begin
            errors++;
            $display("FAIL b2b_first: got v=%b pc=%h expected v=1 pc=380", InstrValid_o, InstrPC_o);
        end
    endtask

    task automatic test_misalign;
        do_reset;
        Redirect_i = 1; RedirectPC_i = 32'h102;
        #1;
        checks++;
        if (ImemReq_o !== 1'b0) begin errors++; $display("FAIL mis_req: got %b expected 0", ImemReq_o); end
        tick;
        Redirect_i = 0;
        #1;
`ifdef IFU_MISALIGN_CHK_EN
        checks++;
        if (MisalignErr_o !== 1'b1 || ImemReq_o !== 1'b0) begin
            errors++;
            $display("FAIL mis_err: got err=%b req=%b expected err=1 req=0", MisalignErr_o, ImemReq_o);
        end
        repeat (4) tick;
        checks++;
        if (MisalignErr_o !== 1'b1 || ImemReq_o !== 1'b0) begin
            errors++;
            $display("FAIL mis_parked: got err=%b req=%b expected err=1 req=0", MisalignErr_o, ImemReq_o);
        end
        do_reset;
        checks++;
        if (MisalignErr_o !== 1'b0 || ImemReq_o !== 1'b1 || ImemAddr_o !== 32'h0) begin
            errors++;
            $display("FAIL mis_clear: got err=%b req=%b addr=%h expected err=0 req=1 addr=0", MisalignErr_o, ImemReq_o, ImemAddr_o);
        end
`else
        checks++;
        if (ImemReq_o !== 1'b1 || ImemAddr_o !== 32'h100) begin
            errors++;
            $display("FAIL mis_align: got req=%b addr=%h expected req=1 addr=100", ImemReq_o, ImemAddr_o);
        end
        repeat (2) tick;
        checks++;
        if (InstrValid_o !== 1'b1 || InstrPC_o !== 32'h100 || Instr_o !== word(32'h100)) begin
            errors++;
            $display("FAIL mis_first: got v=%b pc=%h expected v=1 pc=100", InstrValid_o, InstrPC_o);
        end
`endif
    endtask

    task automatic test_reset_mid;
        do_reset;
        tick;
        rst_ni = 0;
        #1;
        checks++;
        if (ImemReq_o !== 1'b0 || InstrValid_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_now: got req=%b v=%b expected req=0 v=0", ImemReq_o, InstrValid_o);
        end
        repeat (2) tick;
        rst_ni = 1;
        #1;
        checks++;
        if (ImemReq_o !== 1'b1 || ImemAddr_o !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_restart: got req=%b addr=%h expected req=1 addr=0", ImemReq_o, ImemAddr_o);
        end
        repeat (2) tick;
        checks++;
        if (InstrValid_o !== 1'b1 || InstrPC_o !== 32'h0 || Instr_o !== word(32'h0)) begin
            errors++;
            $display("FAIL rstmid_first: got v=%b pc=%h expected v=1 pc=0", InstrValid_o, InstrPC_o);
        end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_flush;
        test_redirect;
        test_redirect_concurrent;
        test_back_to_back;
        test_misalign;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
